// File: rtl/axi_to_umi_wr_pkg.sv
// Shared constants and types for the AXI write-channel to UMI bridge.
package axi_to_umi_wr_pkg;

  // UMI field widths
  localparam int UMI_OPCODE_W = 8;
  localparam int UMI_SIZE_W   = 4;
  localparam int UMI_USER_W   = 20;
  localparam int UMI_ADDR_W   = 64;
  localparam int UMI_DATA_W   = 256;
  localparam int UMI_PACKET_W = 256;

  // The command word sits in the low bits of every packet.
  localparam int UMI_CMD_W = UMI_OPCODE_W + UMI_SIZE_W + UMI_USER_W;

  // Payload bits that fit after cmd, dstaddr, srcaddr and the burst flag.
  localparam int UMI_DATA_CARRIED_W = UMI_PACKET_W - UMI_CMD_W - 2 * UMI_ADDR_W - 1;

  // UMI write request opcode
  localparam logic [UMI_OPCODE_W-1:0] UMI_REQ_WRITE = 8'h01;

  // AXI OKAY response code
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef struct packed {
    logic [UMI_USER_W-1:0]   user;
    logic [UMI_SIZE_W-1:0]   size;
    logic [UMI_OPCODE_W-1:0] opcode;
  } umi_cmd_t;

endpackage

// File: rtl/axi_to_umi_wr_umi_id_fifo.sv
// Synchronous FIFO of AXI IDs used as the B-response queue.
// Push when full and pop when empty are ignored.
module umi_id_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Next pointers, count and storage; pointers wrap modulo DEPTH.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; entries are only read when counted valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/umi_pack.sv
// Packs UMI command, addresses and payload into one 256-bit packet.
// Layout, LSB first: cmd[31:0], dstaddr[95:32], srcaddr[159:96],
// burst[160], data[255:161] (the low 95 payload bits).
module umi_pack
  import axi_to_umi_wr_pkg::*;
(
  input  logic [UMI_OPCODE_W-1:0] opcode,
  input  logic [UMI_SIZE_W-1:0]   size,
  input  logic [UMI_USER_W-1:0]   user,
  input  logic                    burst,
  input  logic [UMI_ADDR_W-1:0]   dstaddr,
  input  logic [UMI_ADDR_W-1:0]   srcaddr,
  input  logic [UMI_DATA_W-1:0]   data,
  output logic [UMI_PACKET_W-1:0] packet
);

  umi_cmd_t cmd;
  logic     unused_data;

  // Assemble the command word and the packet.
  always_comb begin
    cmd.opcode = opcode;
    cmd.size   = size;
    cmd.user   = user;
    packet     = {data[UMI_DATA_CARRIED_W-1:0], burst, srcaddr, dstaddr, cmd};
  end

  // Payload bits beyond the packet capacity are intentionally dropped.
  assign unused_data = ^data[UMI_DATA_W-1:UMI_DATA_CARRIED_W];

endmodule

// File: rtl/axi_to_umi_wr.sv
// AXI write (AW/W/B) to UMI write-packet bridge.
// Handshake rule on every channel: a transfer happens on a rising clk edge
// where valid and ready are both high; valid, once raised, holds its payload
// until that transfer. umi_valid never depends on umi_ready; the only
// combinational input-to-output path is umi_ready -> axi_awready/axi_wready.
module axi_to_umi_wr
  import axi_to_umi_wr_pkg::*;
#(
  parameter int               AW       = 64,
  parameter int               DW       = 256,
  parameter int               IDW      = 4,
  parameter int               BQ_DEPTH = 4,
  parameter logic [7:0]       OPCODE   = 8'd0,
  parameter logic [3:0]       SIZE     = 4'd0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            axi_awvalid,
  output logic                            axi_awready,
  input  logic [AW-1:0]                   axi_awaddr,
  input  logic [IDW-1:0]                  axi_awid,
  input  logic                            axi_wvalid,
  output logic                            axi_wready,
  input  logic [DW-1:0]                   axi_wdata,
  output logic                            axi_bvalid,
  input  logic                            axi_bready,
  output logic [IDW-1:0]                  axi_bid,
  output logic [1:0]                      axi_bresp,
  output logic [UMI_PACKET_W-1:0]         umi_packet,
  output logic                            umi_valid,
  input  logic                            umi_ready,
  output logic [$clog2(BQ_DEPTH+1)-1:0]   bq_count
);

  logic                  aw_full_q, aw_full_d;
  logic [AW-1:0]         aw_addr_q, aw_addr_d;
  logic [IDW-1:0]        aw_id_q, aw_id_d;
  logic                  w_full_q, w_full_d;
  logic [DW-1:0]         w_data_q, w_data_d;
  logic                  fire, aw_hs, w_hs;
  logic                  bq_full, bq_empty;
  logic [UMI_ADDR_W-1:0] dst_ext;
  logic [UMI_DATA_W-1:0] data_ext;

  // A held register frees up in the same cycle its packet is accepted.
  assign fire        = umi_valid & umi_ready;
  assign axi_awready = ~aw_full_q | fire;
  assign axi_wready  = ~w_full_q | fire;
  assign aw_hs       = axi_awvalid & axi_awready;
  assign w_hs        = axi_wvalid & axi_wready;

  // Registered count only: a same-cycle B pop cannot unblock umi_valid.
  assign umi_valid   = aw_full_q & w_full_q & ~bq_full;
  assign axi_bvalid  = ~bq_empty;
  assign axi_bresp   = AXI_RESP_OKAY;

  // Next state of the AW and W holding registers.
  always_comb begin
    aw_full_d = (aw_full_q & ~fire) | aw_hs;
    aw_addr_d = aw_addr_q;
    aw_id_d   = aw_id_q;
    w_full_d  = (w_full_q & ~fire) | w_hs;
    w_data_d  = w_data_q;
    if (aw_hs) begin
      aw_addr_d = axi_awaddr;
      aw_id_d   = axi_awid;
    end
    if (w_hs) begin
      w_data_d = axi_wdata;
    end
  end

  // Occupancy flags, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
    end else begin
      aw_full_q <= aw_full_d;
      w_full_q  <= w_full_d;
    end
  end

  // Payload registers; only meaningful while the matching flag is set.
  always_ff @(posedge clk) begin
    aw_addr_q <= aw_addr_d;
    aw_id_q   <= aw_id_d;
    w_data_q  <= w_data_d;
  end

  // Zero-extend held address and data into the UMI field widths.
  always_comb begin
    dst_ext              = '0;
    dst_ext[AW-1:0]      = aw_addr_q;
    data_ext             = '0;
    data_ext[DW-1:0]     = w_data_q;
  end

  umi_pack u_pack (
    .opcode  (OPCODE),
    .size    (SIZE),
    .user    ({UMI_USER_W{1'b0}}),
    .burst   (1'b0),
    .dstaddr (dst_ext),
    .srcaddr ({UMI_ADDR_W{1'b0}}),
    .data    (data_ext),
    .packet  (umi_packet)
  );

  // B queue: ids pushed when UMI accepts, popped on the B handshake.
  umi_id_fifo #(
    .WIDTH (IDW),
    .DEPTH (BQ_DEPTH)
  ) u_bq (
    .clk   (clk),
    .rst   (rst),
    .push  (fire),
    .din   (aw_id_q),
    .pop   (axi_bvalid & axi_bready),
    .dout  (axi_bid),
    .empty (bq_empty),
    .full  (bq_full),
    .count (bq_count)
  );

endmodule
